// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//
// Multicycle fetch/update controller for the program_counter register.
// Each instruction walks FETCH -> ISSUE -> UPDATE: fetch the word at the
// current PC over a req/ack handshake, hold it for the control unit until
// execution finishes, then write the selected next PC with a one-cycle
// W_PC pulse. A fetch that never completes parks the block in ERROR and a
// halting instruction parks it in HALTED; only reset leaves either state.
//
// Ports
//   CLK            in   1   clock, rising edge
//   RST_N          in   1   asynchronous active-low reset
//   pc_cur         in   32  current PC from program_counter.out
//   pc_next        out  32  value for program_counter.in
//   W_PC           out  1   program_counter write enable (single-cycle pulse)
//   imem_req       out  1   instruction fetch request
//   imem_addr      out  32  fetch address (pc_cur during FETCH, else 0)
//   imem_ack       in   1   fetch complete, imem_rdata valid this cycle
//   imem_rdata     in   32  fetched instruction word
//   instr          out  32  registered instruction for the control unit
//   instr_valid    out  1   instr is awaiting execution
//   exec_done      in   1   control unit finished the current instruction
//   branch_taken   in   1   take branch_target (sampled with exec_done)
//   branch_target  in   32  branch destination
//   jump           in   1   take jump_target (sampled with exec_done)
//   jump_target    in   32  jump destination
//   halt           in   1   stop after this PC update (sampled with exec_done)
//   stall          in   1   hold the pending PC write while high
//   halted         out  1   sticky, HALTED state reached
//   fetch_err      out  1   sticky, fetch timed out
// ---------------------------------------------------------------------------
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] PC_STEP      = 32'd1,
    parameter int unsigned MEM_TIMEOUT  = 15
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] pc_cur,
    output logic [31:0] pc_next,
    output logic        W_PC,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        exec_done,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        halt,
    input  logic        stall,
    output logic        halted,
    output logic        fetch_err
);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_FETCH,
        ST_ISSUE,
        ST_UPDATE,
        ST_HALTED,
        ST_ERROR
    } state_e;

    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

    state_e      state_q, state_d;
    logic [7:0]  timeoutCnt_q, timeoutCnt_d;
    logic [31:0] instr_q, instr_d;
    logic        instrValid_q, instrValid_d;
    logic [31:0] nextPc_q, nextPc_d;
    logic        haltPend_q, haltPend_d;

    // State and datapath registers; reset drops any fetch in flight.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= ST_INIT;
            timeoutCnt_q <= '0;
            instr_q      <= '0;
            instrValid_q <= 1'b0;
            nextPc_q     <= '0;
            haltPend_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            timeoutCnt_q <= timeoutCnt_d;
            instr_q      <= instr_d;
            instrValid_q <= instrValid_d;
            nextPc_q     <= nextPc_d;
            haltPend_q   <= haltPend_d;
        end
    end

    // Next-state logic. Inputs are only looked at in the state that owns
    // them, so stray acks, exec_done or stall elsewhere have no effect.
    always_comb begin
        state_d      = state_q;
        timeoutCnt_d = timeoutCnt_q;
        instr_d      = instr_q;
        instrValid_d = instrValid_q;
        nextPc_d     = nextPc_q;
        haltPend_d   = haltPend_q;
        unique case (state_q)
            ST_INIT: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    instr_d      = imem_rdata;
                    instrValid_d = 1'b1;
                    timeoutCnt_d = '0;
                    state_d      = ST_ISSUE;
                end else begin
                    // Count this ack-less cycle; the last allowed one ends the fetch.
                    timeoutCnt_d = timeoutCnt_q + 8'd1;
                    if (timeoutCnt_d == TIMEOUT_CNT) begin
                        state_d = ST_ERROR;
                    end
                end
            end
            ST_ISSUE: begin
                if (exec_done) begin
                    if (jump) begin
                        nextPc_d = jump_target;
                    end else if (branch_taken) begin
                        nextPc_d = branch_target;
                    end else begin
                        nextPc_d = pc_cur + PC_STEP;
                    end
                    haltPend_d   = halt;
                    instrValid_d = 1'b0;
                    state_d      = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                if (!stall) begin
                    state_d = haltPend_q ? ST_HALTED : ST_FETCH;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            ST_ERROR: begin
                state_d = ST_ERROR;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Output decode. The INIT write is qualified with RST_N so that no write
    // is requested while reset is held; stall gates the UPDATE write in the
    // same cycle so a stalled update never reaches program_counter.
    always_comb begin
        W_PC        = (RST_N && (state_q == ST_INIT)) ||
                      ((state_q == ST_UPDATE) && !stall);
        pc_next     = (state_q == ST_UPDATE) ? nextPc_q : RESET_VECTOR;
        imem_req    = (state_q == ST_FETCH);
        imem_addr   = (state_q == ST_FETCH) ? pc_cur : 32'h0;
        instr       = instr_q;
        instr_valid = instrValid_q;
        halted      = (state_q == ST_HALTED);
        fetch_err   = (state_q == ST_ERROR);
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_pc_sequencer
//
// Bench for pc_sequencer. A small program_counter register is kept here and
// written by W_PC/pc_next, so pc_cur follows the DUT exactly as in the real
// datapath. Expected PCs come from a plain arithmetic model of the
// jump > branch > sequential selection.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

    localparam logic [31:0] RV = 32'h0000_0000;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b1;
    logic [31:0] pc_cur;
    logic [31:0] pc_next;
    logic        W_PC;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        exec_done;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        halt;
    logic        stall;
    logic        halted;
    logic        fetch_err;

    logic [31:0] pcReg;
    logic [31:0] modelPc;
    int          testsRun = 0;
    int          testsFailed = 0;

    typedef struct {
        logic        reqAtStart;
        logic [31:0] addr;
        bit          addrStable;
        logic [31:0] instr;
        logic        valid;
        logic [31:0] instrLate;
        logic        validInUpdate;
        int          stray;
        int          stallLow;
        bit          pcHeld;
        logic        pulse;
        logic [31:0] pc;
        logic        reqAfter;
        logic [31:0] addrAfter;
        logic        haltedAfter;
    } obs_t;

    pc_sequencer #(
        .RESET_VECTOR(RV),
        .PC_STEP(32'd1),
        .MEM_TIMEOUT(15)
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .pc_cur(pc_cur),
        .pc_next(pc_next),
        .W_PC(W_PC),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .instr(instr),
        .instr_valid(instr_valid),
        .exec_done(exec_done),
        .branch_taken(branch_taken),
        .branch_target(branch_target),
        .jump(jump),
        .jump_target(jump_target),
        .halt(halt),
        .stall(stall),
        .halted(halted),
        .fetch_err(fetch_err)
    );

    always #5 CLK = ~CLK;

    // Stand-in for program_counter; its own reset value differs from the
    // reset vector so the INIT write is visible on imem_addr.
    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pcReg <= 32'h0000_0BAD;
        end else if (W_PC) begin
            pcReg <= pc_next;
        end
    end
    assign pc_cur = pcReg;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic nextCycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic idleInputs();
        imem_ack      = 1'b0;
        imem_rdata    = 32'h0;
        exec_done     = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        jump          = 1'b0;
        jump_target   = 32'h0;
        halt          = 1'b0;
        stall         = 1'b0;
    endtask

    // Leaves the bench inside the INIT cycle right after reset release.
    task automatic applyReset();
        RST_N = 1'b0;
        idleInputs();
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        #1;
    endtask

    // Drives one complete FETCH/ISSUE/UPDATE pass starting in a FETCH cycle
    // and records what the DUT showed; the calling test judges the record.
    task automatic runInstr(input logic [31:0] rdata, input int ackDelay, input int execDelay,
                            input logic jumpIn, input logic [31:0] jt,
                            input logic brIn, input logic [31:0] bt,
                            input logic haltIn, input int stallCycles, input bit noise,
                            output obs_t o);
        o.reqAtStart = imem_req;
        o.addr = imem_addr;
        o.addrStable = 1'b1;
        o.stray = 0;
        o.stallLow = 0;
        o.pcHeld = 1'b1;
        for (int i = 0; i < ackDelay; i++) begin
            imem_ack = 1'b0;
            if (noise) begin
                exec_done = 1'($urandom); jump = 1'($urandom);
                branch_taken = 1'($urandom); halt = 1'($urandom); stall = 1'($urandom);
            end
            #1;
            if (W_PC) o.stray++;
            if (imem_req !== 1'b1 || imem_addr !== o.addr) o.addrStable = 1'b0;
            nextCycle();
        end
        idleInputs();
        imem_ack = 1'b1;
        imem_rdata = rdata;
        #1;
        if (W_PC) o.stray++;
        if (imem_req !== 1'b1 || imem_addr !== o.addr) o.addrStable = 1'b0;
        nextCycle();
        imem_ack = 1'b0;
        imem_rdata = $urandom;
        o.instr = instr;
        o.valid = instr_valid;
        for (int i = 0; i < execDelay; i++) begin
            if (noise) begin
                imem_ack = 1'($urandom); imem_rdata = $urandom; stall = 1'($urandom);
            end
            #1;
            if (W_PC) o.stray++;
            nextCycle();
        end
        idleInputs();
        o.instrLate = instr;
        exec_done = 1'b1; jump = jumpIn; jump_target = jt;
        branch_taken = brIn; branch_target = bt; halt = haltIn;
        if (noise) stall = 1'($urandom);
        #1;
        if (W_PC) o.stray++;
        nextCycle();
        idleInputs();
        if (noise) begin
            jump_target = $urandom; branch_target = $urandom;
        end
        o.validInUpdate = instr_valid;
        o.pc = 32'h0;
        for (int s = 0; s < stallCycles; s++) begin
            stall = 1'b1;
            if (noise) begin
                exec_done = 1'($urandom); jump = 1'($urandom); halt = 1'($urandom);
            end
            #1;
            if (!W_PC) o.stallLow++;
            if (s == 0) o.pc = pc_next;
            else if (pc_next !== o.pc) o.pcHeld = 1'b0;
            nextCycle();
        end
        idleInputs();
        #1;
        o.pulse = W_PC;
        if (stallCycles > 0 && pc_next !== o.pc) o.pcHeld = 1'b0;
        o.pc = pc_next;
        nextCycle();
        o.reqAfter = imem_req;
        o.addrAfter = imem_addr;
        o.haltedAfter = halted;
    endtask

    task automatic test_reset();
        idleInputs();
        #2;
        RST_N = 1'b0;
        #1;
        testsRun++; if (W_PC !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_wpc: got %b expected 0", W_PC); end
        testsRun++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_req: got req=%b addr=%h expected 0/0", imem_req, imem_addr); end
        testsRun++; if (instr !== 32'h0 || instr_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_instr: got %h/%b expected 0/0", instr, instr_valid); end
        testsRun++; if (halted !== 1'b0 || fetch_err !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_flags: got halted=%b err=%b expected 0/0", halted, fetch_err); end
        testsRun++; if (pc_next !== RV) begin testsFailed++; $display("[TB] FAIL reset_pcnext: got %h expected %h", pc_next, RV); end
        repeat (2) @(posedge CLK);
        #1;
        testsRun++; if (W_PC !== 1'b0 || imem_req !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_held: got wpc=%b req=%b expected 0/0", W_PC, imem_req); end
        RST_N = 1'b1;
        #1;
        testsRun++; if (W_PC !== 1'b1 || pc_next !== RV) begin testsFailed++; $display("[TB] FAIL init_write: got wpc=%b pc=%h expected 1/%h", W_PC, pc_next, RV); end
        nextCycle();
        testsRun++; if (imem_req !== 1'b1 || imem_addr !== RV) begin testsFailed++; $display("[TB] FAIL first_fetch: got req=%b addr=%h expected 1/%h", imem_req, imem_addr, RV); end
    endtask

    task automatic test_sequential();
        obs_t o;
        logic [31:0] w;
        applyReset();
        testsRun++; if (W_PC !== 1'b1 || pc_next !== RV) begin testsFailed++; $display("[TB] FAIL seq_init: got wpc=%b pc=%h expected 1/%h", W_PC, pc_next, RV); end
        nextCycle();
        modelPc = RV;
        for (int k = 0; k < 3; k++) begin
            w = $urandom;
            runInstr(w, 0, 0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 0, 1'b0, o);
            testsRun++; if (o.addr !== modelPc) begin testsFailed++; $display("[TB] FAIL seq_addr%0d: got %h expected %h", k, o.addr, modelPc); end
            testsRun++; if (o.instr !== w || o.valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL seq_instr%0d: got %h/%b expected %h/1", k, o.instr, o.valid, w); end
            testsRun++; if (o.pulse !== 1'b1 || o.pc !== modelPc + 32'd1) begin testsFailed++; $display("[TB] FAIL seq_pc%0d: got wpc=%b pc=%h expected 1/%h", k, o.pulse, o.pc, modelPc + 32'd1); end
            modelPc = modelPc + 32'd1;
        end
    endtask

    task automatic test_jump_priority();
        obs_t o;
        runInstr(32'hDEAD_BEEF, 1, 1, 1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 0, 1'b0, o);
        testsRun++; if (o.instr !== 32'hDEAD_BEEF || o.instrLate !== 32'hDEAD_BEEF) begin testsFailed++; $display("[TB] FAIL jmp_instr: got %h/%h expected deadbeef", o.instr, o.instrLate); end
        testsRun++; if (o.validInUpdate !== 1'b0) begin testsFailed++; $display("[TB] FAIL jmp_valid_clear: got %b expected 0", o.validInUpdate); end
        testsRun++; if (o.pulse !== 1'b1 || o.pc !== 32'h40) begin testsFailed++; $display("[TB] FAIL jmp_pc: got wpc=%b pc=%h expected 1/00000040", o.pulse, o.pc); end
        testsRun++; if (o.addrAfter !== 32'h40) begin testsFailed++; $display("[TB] FAIL jmp_addr: got %h expected 00000040", o.addrAfter); end
        runInstr(32'h1234_5678, 0, 0, 1'b0, 32'h99, 1'b1, 32'h123, 1'b0, 0, 1'b0, o);
        testsRun++; if (o.pc !== 32'h123 || o.addrAfter !== 32'h123) begin testsFailed++; $display("[TB] FAIL br_pc: got pc=%h addr=%h expected 00000123", o.pc, o.addrAfter); end
        modelPc = 32'h123;
    endtask

    task automatic test_wrap();
        obs_t o;
        runInstr(32'h0, 0, 0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0, 0, 1'b0, o);
        testsRun++; if (o.addrAfter !== 32'hFFFF_FFFF) begin testsFailed++; $display("[TB] FAIL wrap_setup: got %h expected ffffffff", o.addrAfter); end
        runInstr(32'h5, 0, 0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 0, 1'b0, o);
        testsRun++; if (o.pulse !== 1'b1 || o.pc !== 32'h0) begin testsFailed++; $display("[TB] FAIL wrap_pc: got wpc=%b pc=%h expected 1/00000000", o.pulse, o.pc); end
        modelPc = 32'h0;
    endtask

    task automatic test_stall();
        obs_t o;
        runInstr(32'hCAFE_0001, 0, 2, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4, 1'b0, o);
        testsRun++; if (o.stallLow !== 4 || o.stray !== 0) begin testsFailed++; $display("[TB] FAIL stall_low: got low=%0d stray=%0d expected 4/0", o.stallLow, o.stray); end
        testsRun++; if (o.pcHeld !== 1'b1 || o.pulse !== 1'b1 || o.pc !== modelPc + 32'd1) begin testsFailed++; $display("[TB] FAIL stall_pulse: got held=%b wpc=%b pc=%h expected 1/1/%h", o.pcHeld, o.pulse, o.pc, modelPc + 32'd1); end
        modelPc = modelPc + 32'd1;
    endtask

    task automatic test_timeout();
        obs_t o;
        int reqCycles;
        int wpcSeen;
        int badIdle;
        applyReset();
        nextCycle();
        runInstr(32'h7, 14, 0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 0, 1'b0, o);
        testsRun++; if (o.pulse !== 1'b1 || o.pc !== 32'h1 || o.addrStable !== 1'b1 || fetch_err !== 1'b0) begin testsFailed++; $display("[TB] FAIL slow_ack: got wpc=%b pc=%h stable=%b err=%b expected 1/1/1/0", o.pulse, o.pc, o.addrStable, fetch_err); end
        reqCycles = 0;
        wpcSeen = 0;
        for (int c = 0; c < 40; c++) begin
            imem_ack = 1'b0;
            #1;
            if (!imem_req) break;
            reqCycles++;
            if (W_PC) wpcSeen++;
            nextCycle();
        end
        testsRun++; if (reqCycles !== 15 || wpcSeen !== 0) begin testsFailed++; $display("[TB] FAIL timeout_len: got %0d fetch cycles, %0d writes expected 15/0", reqCycles, wpcSeen); end
        badIdle = 0;
        for (int c = 0; c < 4; c++) begin
            imem_ack = 1'($urandom); exec_done = 1'($urandom); stall = 1'($urandom);
            #1;
            if (fetch_err !== 1'b1 || imem_req !== 1'b0 || W_PC !== 1'b0) badIdle++;
            nextCycle();
        end
        idleInputs();
        testsRun++; if (badIdle !== 0) begin testsFailed++; $display("[TB] FAIL error_state: got %0d bad cycles expected 0", badIdle); end
        RST_N = 1'b0;
        #1;
        testsRun++; if (fetch_err !== 1'b0) begin testsFailed++; $display("[TB] FAIL err_clear: got %b expected 0", fetch_err); end
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        #1;
        testsRun++; if (W_PC !== 1'b1 || pc_next !== RV) begin testsFailed++; $display("[TB] FAIL err_init: got wpc=%b pc=%h expected 1/%h", W_PC, pc_next, RV); end
        nextCycle();
        testsRun++; if (imem_addr !== RV) begin testsFailed++; $display("[TB] FAIL err_refetch: got %h expected %h", imem_addr, RV); end
        RST_N = 1'b0;
        #1;
        testsRun++; if (imem_req !== 1'b0) begin testsFailed++; $display("[TB] FAIL async_drop: got req=%b expected 0", imem_req); end
        applyReset();
    endtask

    task automatic test_halt();
        obs_t o;
        int badIdle;
        applyReset();
        nextCycle();
        runInstr(32'h0, 0, 0, 1'b1, 32'h5, 1'b0, 32'h0, 1'b0, 0, 1'b0, o);
        testsRun++; if (o.addrAfter !== 32'h5) begin testsFailed++; $display("[TB] FAIL halt_setup: got %h expected 00000005", o.addrAfter); end
        runInstr(32'hF00D, 0, 1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 0, 1'b0, o);
        testsRun++; if (o.pulse !== 1'b1 || o.pc !== 32'h6) begin testsFailed++; $display("[TB] FAIL halt_pc: got wpc=%b pc=%h expected 1/00000006", o.pulse, o.pc); end
        testsRun++; if (o.haltedAfter !== 1'b1 || o.reqAfter !== 1'b0) begin testsFailed++; $display("[TB] FAIL halt_enter: got halted=%b req=%b expected 1/0", o.haltedAfter, o.reqAfter); end
        badIdle = 0;
        for (int c = 0; c < 6; c++) begin
            imem_ack = 1'($urandom); exec_done = 1'($urandom); jump = 1'($urandom); stall = 1'($urandom);
            #1;
            if (halted !== 1'b1 || imem_req !== 1'b0 || W_PC !== 1'b0) badIdle++;
            nextCycle();
        end
        idleInputs();
        testsRun++; if (badIdle !== 0) begin testsFailed++; $display("[TB] FAIL halt_idle: got %0d bad cycles expected 0", badIdle); end
    endtask

    task automatic test_random();
        obs_t o;
        logic [31:0] w, jt, bt, expPc;
        logic jIn, bIn;
        int stl;
        applyReset();
        nextCycle();
        modelPc = RV;
        for (int n = 0; n < 25; n++) begin
            w = $urandom; jt = $urandom; bt = $urandom;
            jIn = ($urandom_range(3) == 0);
            bIn = ($urandom_range(2) == 0);
            stl = $urandom_range(3);
            expPc = jIn ? jt : (bIn ? bt : modelPc + 32'd1);
            runInstr(w, $urandom_range(6), $urandom_range(3), jIn, jt, bIn, bt, 1'b0, stl, 1'b1, o);
            testsRun++;
            if (o.reqAtStart !== 1'b1 || o.addr !== modelPc || o.addrStable !== 1'b1 ||
                o.instr !== w || o.instrLate !== w || o.stray !== 0 || o.stallLow !== stl ||
                o.pcHeld !== 1'b1 || o.pulse !== 1'b1 || o.pc !== expPc || o.addrAfter !== expPc) begin
                testsFailed++;
                $display("[TB] FAIL rand%0d: got addr=%h instr=%h/%h stray=%0d low=%0d wpc=%b pc=%h next=%h expected addr=%h instr=%h low=%0d pc=%h",
                         n, o.addr, o.instr, o.instrLate, o.stray, o.stallLow, o.pulse, o.pc, o.addrAfter, modelPc, w, stl, expPc);
            end
            modelPc = expPc;
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_jump_priority();
        test_wrap();
        test_stall();
        test_timeout();
        test_halt();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
